// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Parametrised sequential ALU with valid/ready handshakes on the
//             operand and result sides. Opcodes 0-7 are logic/arithmetic,
//             8/9 are variable-amount shifts (amount taken from B, clamped
//             to ANCHO, ALUFlagIN used as fill bit). Flags are {N, Z, C, V}.
//  Options  : ALU_SEQ_BARREL_EN - single-cycle barrel shifter instead of the
//             one-position-per-cycle iterative shifter.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ANCHO-1:0] A,
    input  logic [ANCHO-1:0] B,
    input  logic             ALUFlagIN,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ANCHO-1:0] ALUResult,
    output logic [3:0]       ALUFlags
);

    // Counter wide enough to hold the clamped shift amount 0..ANCHO
    localparam int               C_CW        = $clog2(ANCHO + 1);
    localparam logic [ANCHO-1:0] C_ANCHO_V   = ANCHO'(ANCHO);
    localparam logic [C_CW-1:0]  C_ANCHO_CNT = C_CW'(ANCHO);
    localparam logic [ANCHO-1:0] C_ONE       = {{(ANCHO-1){1'b0}}, 1'b1};
    localparam logic [ANCHO-1:0] C_MAX_POS   = {1'b0, {(ANCHO-1){1'b1}}};
    localparam logic [ANCHO-1:0] C_MIN_NEG   = {1'b1, {(ANCHO-1){1'b0}}};

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_INC = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    // EXEC is the operand-register stage: operands captured at accept are
    // evaluated there, which gives every single-step op a latency of one.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
`ifndef ALU_SEQ_BARREL_EN
        ST_SHIFT = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ANCHO-1:0] a_q, a_d;       // operand A, doubles as shift working register
    logic [ANCHO-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             fin_q, fin_d;
    logic [ANCHO-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;

    logic [ANCHO:0]   w_sum;
    logic [ANCHO-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_legal;
    logic [3:0]       w_flags;

    // Clamp a raw shift amount to ANCHO
    function automatic logic [C_CW-1:0] clamp_shamt(input logic [ANCHO-1:0] amt);
        return (amt >= C_ANCHO_V) ? C_ANCHO_CNT : amt[C_CW-1:0];
    endfunction

`ifdef ALU_SEQ_BARREL_EN
    logic [C_CW-1:0]  w_exec_shamt;
    logic [2*ANCHO:0] w_shl;
    logic [2*ANCHO:0] w_shr;

    // Shift amount for the barrel shifter, taken from the captured B
    always_comb w_exec_shamt = clamp_shamt(b_q);
`else
    localparam logic [C_CW-1:0] C_CNT_ONE = C_CW'(1);

    logic [C_CW-1:0]  cnt_q, cnt_d;
    logic [ANCHO-1:0] w_step;
    logic             w_step_c;
    logic             w_in_shift;

    // Decide at accept whether the op needs the iterative shift loop
    always_comb w_in_shift = ((ALUControl == OP_SHL) || (ALUControl == OP_SHR))
                             && (clamp_shamt(B) != '0);

    // One shift position per cycle; the bit that falls off becomes carry
    always_comb begin
        if (op_q == OP_SHL) begin
            w_step   = {a_q[ANCHO-2:0], fin_q};
            w_step_c = a_q[ANCHO-1];
        end else begin
            w_step   = {fin_q, a_q[ANCHO-1:1]};
            w_step_c = a_q[0];
        end
    end
`endif

    // Single-step ALU evaluated on the captured operands
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_legal = 1'b1;
`ifdef ALU_SEQ_BARREL_EN
        // Guard bit on the outside catches the last bit shifted out
        w_shl = {1'b0, a_q, {ANCHO{fin_q}}} << w_exec_shamt;
        w_shr = {{ANCHO{fin_q}}, a_q, 1'b0} >> w_exec_shamt;
`endif
        case (op_q)
            OP_AND: w_res = a_q & b_q;
            OP_OR:  w_res = a_q | b_q;
            OP_ADC: begin
                w_sum = {1'b0, a_q} + {1'b0, b_q} + {{ANCHO{1'b0}}, fin_q};
                w_res = w_sum[ANCHO-1:0];
                w_c   = w_sum[ANCHO];
                w_v   = (a_q[ANCHO-1] == b_q[ANCHO-1]) && (w_res[ANCHO-1] != a_q[ANCHO-1]);
            end
            OP_INC: begin
                w_sum = {1'b0, a_q} + {1'b0, C_ONE};
                w_res = w_sum[ANCHO-1:0];
                w_c   = w_sum[ANCHO];
                w_v   = (a_q == C_MAX_POS);
            end
            OP_DEC: begin
                w_res = a_q - C_ONE;
                w_c   = (a_q == '0);
                w_v   = (a_q == C_MIN_NEG);
            end
            OP_NOT: w_res = ~a_q;
            OP_SUB: begin
                w_sum = {1'b0, a_q} + {1'b0, ~b_q} + {1'b0, C_ONE};
                w_res = w_sum[ANCHO-1:0];
                w_c   = w_sum[ANCHO];
                w_v   = (a_q[ANCHO-1] != b_q[ANCHO-1]) && (w_res[ANCHO-1] != a_q[ANCHO-1]);
            end
            OP_XOR: w_res = a_q ^ b_q;
            OP_SHL, OP_SHR: begin
`ifdef ALU_SEQ_BARREL_EN
                if (op_q == OP_SHL) begin
                    w_res = w_shl[2*ANCHO-1:ANCHO];
                    w_c   = w_shl[2*ANCHO];
                end else begin
                    w_res = w_shr[ANCHO:1];
                    w_c   = w_shr[0];
                end
`else
                // Only zero-amount shifts reach this stage in the iterative build
                w_res = a_q;
`endif
            end
            default: w_legal = 1'b0;
        endcase
        w_flags = w_legal ? {w_res[ANCHO-1], (w_res == '0), w_c, w_v} : 4'b0000;
    end

    // Next-state and datapath register update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        fin_d   = fin_q;
        res_d   = res_q;
        flags_d = flags_q;
`ifndef ALU_SEQ_BARREL_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = ALUControl;
                    fin_d   = ALUFlagIN;
                    state_d = ST_EXEC;
`ifndef ALU_SEQ_BARREL_EN
                    if (w_in_shift) begin
                        cnt_d   = clamp_shamt(B);
                        state_d = ST_SHIFT;
                    end
`endif
                end
            end
            ST_EXEC: begin
                res_d   = w_res;
                flags_d = w_flags;
                state_d = ST_DONE;
            end
`ifndef ALU_SEQ_BARREL_EN
            ST_SHIFT: begin
                a_d   = w_step;
                cnt_d = cnt_q - C_CNT_ONE;
                if (cnt_q == C_CNT_ONE) begin
                    res_d   = w_step;
                    flags_d = {w_step[ANCHO-1], (w_step == '0), w_step_c, 1'b0};
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            fin_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
`ifndef ALU_SEQ_BARREL_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            fin_q   <= fin_d;
            res_q   <= res_d;
            flags_q <= flags_d;
`ifndef ALU_SEQ_BARREL_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !reset;
    assign out_valid = (state_q == ST_DONE);
    assign ALUResult = res_q;
    assign ALUFlags  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (ANCHO = 8): directed vector
//             table, randomized ops against a reference model, and hand
//             sequences for backpressure and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       ALUFlagIN;
    logic [3:0] ALUControl;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] ALUResult;
    logic [3:0] ALUFlags;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.ANCHO(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALUFlagIN  (ALUFlagIN),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .ALUFlags   (ALUFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       fin;
        logic [7:0] res;
        logic [3:0] flg;
        int         lat;   // iterative-build latency in cycles
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference ALU from the arithmetic definitions; returns {result, N, Z, C, V}
    function automatic logic [11:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic fin);
        int ai, bi, fi, sa, sb, r, n;
        logic c, v;
        logic [7:0] res;
        ai = a; bi = b; fi = fin;
        sa = $signed(a); sb = $signed(b);
        n = (bi > 8) ? 8 : bi;
        c = 1'b0; v = 1'b0; r = 0;
        case (op)
            4'd0: r = ai & bi;
            4'd1: r = ai | bi;
            4'd2: begin r = ai + bi + fi; c = (r > 255); v = (sa + sb + fi > 127) || (sa + sb + fi < -128); end
            4'd3: begin r = ai + 1; c = (r > 255); v = (ai == 127); end
            4'd4: begin r = ai - 1; c = (ai == 0); v = (ai == 128); end
            4'd5: r = 255 - ai;
            4'd6: begin r = ai + (255 - bi) + 1; c = (r > 255); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd7: r = ai ^ bi;
            4'd8: begin
                r = ai * (1 << n) + (fi != 0 ? (1 << n) - 1 : 0);
                c = (n == 0) ? 1'b0 : (((ai >> (8 - n)) & 1) != 0);
            end
            4'd9: begin
                r = (ai >> n) + (fi != 0 ? 256 - (1 << (8 - n)) : 0);
                c = (n == 0) ? 1'b0 : (((ai >> (n - 1)) & 1) != 0);
            end
            default: return 12'h000;
        endcase
        res = 8'(r & 255);
        return {res, res[7], (res == 8'h00), c, v};
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [7:0] b);
        int n;
        n = (b > 8) ? 8 : int'(b);
`ifdef ALU_SEQ_BARREL_EN
        return 1;
`else
        if ((op == 4'd8 || op == 4'd9) && n > 1) return n;
        return 1;
`endif
    endfunction

    // Issue one op, measure latency, check result, optionally stall, then consume
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic fin, input logic [7:0] e_res, input logic [3:0] e_flg,
                          input int e_lat, input int hold, input string name);
        int t;
        int lat;
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, "/in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; ALUControl = op; A = a; B = b; ALUFlagIN = fin; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 8'($urandom); B = 8'($urandom); ALUControl = 4'($urandom); ALUFlagIN = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "/latency"}, 32'(lat), 32'(e_lat));
        check({name, "/result"},  32'(ALUResult), 32'(e_res));
        check({name, "/flags"},   32'(ALUFlags), 32'(e_flg));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, "/stall"}, {18'd0, out_valid, in_ready, ALUResult, ALUFlags},
                  {18'd0, 1'b1, 1'b0, e_res, e_flg});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "/consume"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    vec_t tab[17];

    initial begin
        logic [3:0]  r_op;
        logic [7:0]  r_a, r_b;
        logic        r_fin;
        logic [11:0] exp;
        int          lat;
        bit          seen;

        tab[0]  = '{4'd2, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001, 1};
        tab[1]  = '{4'd6, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b1000, 1};
        tab[2]  = '{4'd4, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b1010, 1};
        tab[3]  = '{4'd8, 8'h81, 8'h03, 1'b1, 8'h0F, 4'b0000, 3};
        tab[4]  = '{4'hC, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0000, 1};
        tab[5]  = '{4'd0, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 1};
        tab[6]  = '{4'd1, 8'h00, 8'h00, 1'b1, 8'h00, 4'b0100, 1};
        tab[7]  = '{4'd3, 8'h7F, 8'h00, 1'b0, 8'h80, 4'b1001, 1};
        tab[8]  = '{4'd3, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b0110, 1};
        tab[9]  = '{4'd4, 8'h80, 8'h00, 1'b0, 8'h7F, 4'b0001, 1};
        tab[10] = '{4'd5, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b0100, 1};
        tab[11] = '{4'd7, 8'hAA, 8'hFF, 1'b0, 8'h55, 4'b0000, 1};
        tab[12] = '{4'd9, 8'h80, 8'h08, 1'b1, 8'hFF, 4'b1010, 8};
        tab[13] = '{4'd8, 8'h01, 8'hC8, 1'b0, 8'h00, 4'b0110, 8};
        tab[14] = '{4'd8, 8'h55, 8'h00, 1'b1, 8'h55, 4'b0000, 1};
        tab[15] = '{4'd6, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0011, 1};
        tab[16] = '{4'd2, 8'hFF, 8'h01, 1'b1, 8'h01, 4'b0010, 1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; ALUFlagIN = 1'b0; ALUControl = '0;

        // Reset behaviour
        repeat (3) @(posedge clk);
        #1;
        check("reset/outputs", {18'd0, in_ready, out_valid, ALUResult, ALUFlags}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset/in_ready_after", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Directed vectors
        foreach (tab[i]) begin
`ifdef ALU_SEQ_BARREL_EN
            lat = 1;
`else
            lat = tab[i].lat;
`endif
            run_op(tab[i].op, tab[i].a, tab[i].b, tab[i].fin, tab[i].res, tab[i].flg,
                   lat, 0, $sformatf("vec%0d", i));
        end

        // Randomized ops against the reference model
        for (int k = 0; k < 150; k++) begin
            r_op  = 4'($urandom_range(0, 15));
            r_a   = 8'($urandom);
            r_b   = (r_op == 4'd8 || r_op == 4'd9) && ($urandom_range(0, 3) != 0)
                    ? 8'($urandom_range(0, 10)) : 8'($urandom);
            r_fin = 1'($urandom);
            exp   = ref_alu(r_op, r_a, r_b, r_fin);
            run_op(r_op, r_a, r_b, r_fin, exp[11:4], exp[3:0], ref_lat(r_op, r_b),
                   int'($urandom_range(0, 2)), $sformatf("rnd%0d_op%0d", k, r_op));
        end

        // Backpressure: result held while out_ready stays low
        run_op(4'd9, 8'h01, 8'h01, 1'b0, 8'h00, 4'b0110, 1, 5, "backpressure");

        // Reset in the middle of a shift
        @(negedge clk);
        in_valid = 1'b1; ALUControl = 4'd8; A = 8'hFF; B = 8'h08; ALUFlagIN = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_shift/outputs", {18'd0, in_ready, out_valid, ALUResult, ALUFlags}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst_shift/no_stale", 32'(seen), 32'd0);
        check("rst_shift/in_ready", 32'(in_ready), 32'd1);

        // Reset while a result is waiting in DONE clears outputs at once
        @(negedge clk);
        in_valid = 1'b1; ALUControl = 4'd0; A = 8'hFF; B = 8'hFF; ALUFlagIN = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rst_done/pre_result", 32'(ALUResult), 32'hFF);
        #2;
        reset = 1'b1;
        #1;
        check("rst_done/outputs", {19'd0, out_valid, ALUResult, ALUFlags}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // The block still works after reset
        run_op(4'd7, 8'h0F, 8'hF0, 1'b0, 8'hFF, 4'b1000, 1, 0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time guard so the run always terminates
    initial begin
        #500000;
        $display("FAIL timeout: got no finish, want finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 4-bit combinational ALU. Same operation set and encoding, but the width is generic, there is a full N/Z/C/V flag vector, and operands and results are registered behind valid/ready handshakes. Shifts take a variable amount from B and execute iteratively, one position per cycle. The block sits between the operand/decode stage and the writeback stage of the datapath.

## Interface
Parameters:
- `ANCHO`, default 8: operand/result width, ≥ 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: operands and opcode presented.
- `in_ready`, out, 1: block accepts a new operation.
- `A`, in, ANCHO: operand A.
- `B`, in, ANCHO: operand B; also the shift amount for ops 8/9.
- `ALUFlagIN`, in, 1: carry-in for op 2; fill bit for ops 8/9.
- `ALUControl`, in, 4: opcode.
- `out_valid`, out, 1: result and flags valid.
- `out_ready`, in, 1: consumer takes the result.
- `ALUResult`, out, ANCHO: registered result.
- `ALUFlags`, out, 4: registered flags {N, Z, C, V} (bit 3 = N).

## Operation
- Opcodes:
  - 0: A&B
  - 1: A|B
  - 2: A+B+ALUFlagIN
  - 3: A+1
  - 4: A−1
  - 5: ~A
  - 6: A−B (computed as A+~B+1)
  - 7: A^B
  - 8: shift A left
  - 9: shift A right (logical)
  - 10–15: illegal
- Arithmetic is ANCHO bits wide and wraps modulo 2^ANCHO.
- N = result[ANCHO−1].
- Z = (result == 0).
- C:
  - op 2: carry out.
  - op 3: carry out.
  - op 6: carry out of A+~B+1 (1 = no borrow).
  - op 4: 1 iff A == 0 (borrow).
  - ops 8/9: last bit shifted out; 0 if the shift amount is 0.
  - all other ops: 0.
- V:
  - op 2, op 6: two's-complement overflow.
  - op 3: 1 iff A == 0111…1.
  - op 4: 1 iff A == 1000…0.
  - all other ops: 0.
- Shift amount n = min(B, ANCHO). Each step shifts in ALUFlagIN as the fill bit.
- n = ANCHO yields a result of all fill bits; C is then the last bit shifted out: A[0] for op 8, A[ANCHO−1] for op 9.
- Illegal opcode: ALUResult = 0, ALUFlags = 4'b0000 (Z is forced to 0). The operation still completes the handshake.
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready:
    - non-shift op, or shift with n = 0: compute, register, go to DONE.
    - shift with n ≥ 1: load working register with A and counter with n, go to SHIFT.
  - SHIFT: one shift per cycle, counter decrements. After the step that brings the counter to 0, register the result and flags, go to DONE.
  - DONE: out_valid = 1. ALUResult/ALUFlags are held stable. On out_ready, go to IDLE.
- Operands are captured at accept. Changes to A/B/ALUControl after accept have no effect.

## Timing
- Reset, asynchronous: state = IDLE, out_valid = 0, ALUResult = 0, ALUFlags = 0.
- in_ready = (state == IDLE) && !reset, so in_ready is 0 while reset is held.
- Accept at edge k:
  - non-shift op: out_valid = 1 after edge k+1.
  - shift op: out_valid = 1 after edge k+max(1, n).
- in_ready is 0 from the accept edge until the edge that consumes the result. The block never overlaps operations.
- Earliest re-accept: one cycle after the out_valid&&out_ready edge, since IDLE is re-entered on that edge. Peak throughput is one op per 3 cycles for non-shift ops.
- out_ready held 0 stalls in DONE indefinitely; outputs do not change.
- out_ready is ignored outside DONE.
- Reset mid-SHIFT or in DONE aborts the op and the result is lost. Outputs take reset values immediately.

## Configuration
- `ALU_SEQ_BARREL_EN` defined: shifts use a single-cycle barrel shifter. Ops 8/9 take the non-shift path (IDLE→DONE, latency 1) and the SHIFT state is not built. Results and flags are identical to the iterative version.
- Undefined (default): iterative shifter as described, latency max(1, n).

## Test plan
ANCHO = 8 for all scenarios.
- Reset with out_ready = 1:
  - during reset: in_ready = 0, out_valid = 0, ALUResult = 0x00, ALUFlags = 0.
  - after reset release: in_ready = 1.
- op 2, A=0x7F, B=0x01, ALUFlagIN=0: one cycle after accept, out_valid = 1, ALUResult = 0x80, flags N=1 Z=0 C=0 V=1.
- op 6, A=0x00, B=0x01: ALUResult = 0xFF, N=1 C=0 V=0. Then op 4, A=0x00: ALUResult = 0xFF, C=1.
- op 8, A=0x81, B=3, ALUFlagIN=1:
  - iterative build: out_valid exactly 3 cycles after accept, ALUResult = 0x0F, C=0.
  - with ALU_SEQ_BARREL_EN: out_valid after 1 cycle, same result.
- Backpressure: hold out_ready = 0 for 5 cycles after op 9, A=0x01, B=1 → ALUResult = 0x00, Z=1, C=1, held stable and in_ready = 0 throughout. Raise out_ready → IDLE and in_ready = 1 next cycle.
- Illegal op 0xC → ALUResult = 0, flags = 0, completes in 1 cycle. Reset asserted mid-shift (op 8, B=8) → out_valid = 0 immediately, no stale result afterwards.
